uart_tx_fifo_arbiter: RTL and testbench
=======================================

// Module: uart_tx_fifo_arbiter
// PURPOSE
//  Shares the single write port of the UART TX FIFO between N byte-stream requesters.
//  Round-robin grant, packet-atomic: a grant holds until the owner's last byte is written.
//  Stalls on FIFO full; aborts a stalled owner after a timeout.
//  Sits between command/status producers and the TX FIFO feeding the UART transmitter.
// PARAMETERS
//  N        4    number of requesters (2..8)
//  B        8    data bits per word; must match the FIFO's B
//  TIMEOUT  255  idle-owner cycles before abort (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
//  i_clk           in   1    clock
//  i_reset         in   1    asynchronous, active-high reset
//  i_req           in   N    requester i has a byte valid on its data lane
//  i_data          in   N*B  lane i = i_data[i*B +: B]
//  i_last          in   N    lane i byte is the last of its packet (qualified by i_req[i])
//  o_ack           out  N    one-hot; byte on lane i accepted this cycle
//  o_grant         out  N    one-hot registered owner; all-zero when idle
//  i_fifo_full     in   1    TX FIFO full flag
//  o_fifo_wr       out  1    TX FIFO write strobe
//  o_fifo_wr_data  out  B    TX FIFO write data
//  o_abort         out  1    1-cycle pulse: owner released by timeout
//  o_busy          out  1    1 while in GRANT
// BEHAVIOUR
//  Reset (async): state=IDLE, o_grant=0, rr pointer=0, timeout count=0, o_abort=0.
//   Combinational outputs are then 0 (o_ack, o_fifo_wr, o_busy); o_fifo_wr_data=0.
//  FSM IDLE -> GRANT:
//   any i_req set: owner = first set bit searching ptr, ptr+1, ... mod N.
//   o_grant registered at that edge; no write in the IDLE cycle.
//  GRANT, owner g:
//   o_fifo_wr = i_req[g] & ~i_fifo_full; o_ack[g] = o_fifo_wr.
//   o_fifo_wr_data = lane g whenever in GRANT, else 0.
//   Write with i_last[g]=1: next state IDLE, ptr <= (g+1) mod N, o_grant <= 0.
//   i_req[g]=0: count++. Accepted write: count=0. Full stall with i_req[g]=1: count holds.
//   count reaches TIMEOUT: o_abort pulses next cycle, state IDLE, ptr <= (g+1) mod N, count=0.
//  Latency: req in IDLE cycle k -> o_grant at k+1 -> first o_fifo_wr at k+1 if not full.
//   Min 1 idle cycle between packets.
//  Throughput: 1 byte/cycle while owner requesting and FIFO not full.
//  Non-owner requests are ignored (o_ack=0) until re-arbitration; no starvation,
//   since each requester waits at most N-1 packets.
//  Boundaries:
//   i_fifo_full at the last byte: no write; grant holds until the byte is accepted.
//   Single-byte packet (i_last with first byte): 1 write, then IDLE.
//   Pointer wrap: g=N-1 -> ptr=0.
//   i_req[g] drops mid-packet: grant held, no write, timeout runs.
//   i_reset mid-packet: immediate IDLE; bytes already written remain in the FIFO.
//   Partial packets are the producer's concern.
// STRUCTURE
//  uart_defs.vh: state encodings (ST_IDLE, ST_GRANT), default B.
//  Sub-module rr_pick (combinational): inputs req[N], ptr -> one-hot sel[N], index, any.
//  Top level holds FSM, owner/ptr registers, timeout counter, data mux.
// TESTING
//  1. N=4; req=0001, 3-byte packet 0x41,0x42,0x43 (last on 0x43), FIFO empty
//     -> grant=0001 next cycle, 3 consecutive writes, then IDLE, ptr=1.
//  2. req=1111 held, each packet 1 byte
//     -> grant order 0,1,2,3,0; one write every 2 cycles.
//  3. Owner 2 mid-packet, i_fifo_full=1 for 10 cycles
//     -> o_fifo_wr=0, o_ack=0, no abort, count holds; resumes the cycle full drops.
//  4. TIMEOUT=5; owner 1 drops req after 1 byte
//     -> o_abort pulse 5 cycles later, IDLE, ptr=2; req=0011 then grants 0.
//  5. i_reset asserted mid-packet between edges
//     -> o_grant=0, o_fifo_wr=0 immediately; after release, req=1000 grants 3 first
//        (ptr back to 0, search 0..3).
//  6. Last byte (0x0D, owner 3) presented with FIFO full for 3 cycles
//     -> exactly 1 write of 0x0D, ptr wraps to 0.

Source files
------------

// File: rtl/uart_tx_fifo_arbiter_pkg.sv
// Shared definitions for the UART TX FIFO write-port arbiter.
//   state_t   : arbiter FSM states (idle / packet owner granted)
//   DEF_B     : default data width of one FIFO word
//   wrap_inc  : modulo-n increment used for the round-robin pointer
package uart_tx_fifo_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int DEF_B = 8;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req  : N request bits
//   i_ptr  : index searched first; the search continues ptr+1, ... mod N
//   o_sel  : one-hot winner (all-zero when no request)
//   o_idx  : index of the winner
//   o_any  : at least one request present
module uart_tx_fifo_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_sel,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   logic [PW-1:0] cand;

   always_comb begin
      o_sel = '0;
      o_idx = '0;
      o_any = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(i_ptr) + k) % N);
         if (!o_any && i_req[cand]) begin
            o_any       = 1'b1;
            o_sel[cand] = 1'b1;
            o_idx       = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo_arbiter.sv
// Shares the single TX FIFO write port between N byte-stream requesters.
// Round-robin, packet-atomic grant; stalls on FIFO full; releases an owner
// that stops presenting bytes for TIMEOUT cycles.
//   i_clk, i_reset         : clock, asynchronous active-high reset
//   i_req/i_data/i_last    : per-lane byte valid, data (lane i at i*B), end of packet
//   o_ack                  : one-hot, lane byte accepted this cycle
//   o_grant                : registered one-hot owner, zero when idle
//   i_fifo_full            : FIFO cannot accept a write
//   o_fifo_wr/_wr_data     : FIFO write strobe and data
//   o_abort                : one-cycle pulse after a timeout release
//   o_busy                 : an owner is granted
module uart_tx_fifo_arbiter
   import uart_tx_fifo_arbiter_pkg::*;
#(
   parameter int N       = 4,
   parameter int B       = DEF_B,
   parameter int TIMEOUT = 255
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic [N-1:0]   i_req,
   input  logic [N*B-1:0] i_data,
   input  logic [N-1:0]   i_last,
   output logic [N-1:0]   o_ack,
   output logic [N-1:0]   o_grant,
   input  logic           i_fifo_full,
   output logic           o_fifo_wr,
   output logic [B-1:0]   o_fifo_wr_data,
   output logic           o_abort,
   output logic           o_busy
);

   localparam int PW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          abort_q, abort_d;

   logic [N-1:0]  pick_sel;
   logic [PW-1:0] pick_idx;
   logic          pick_any;

   logic          busy;
   logic          own_req;
   logic          own_last;
   logic [B-1:0]  own_data;
   logic          wr;

   uart_tx_fifo_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
      .i_req (i_req),
      .i_ptr (ptr_q),
      .o_sel (pick_sel),
      .o_idx (pick_idx),
      .o_any (pick_any)
   );

   // Owner lane selection
   always_comb begin
      own_data = '0;
      for (int i = 0; i < N; i++) begin
         if (owner_q == PW'(i)) own_data = i_data[i*B +: B];
      end
   end

   assign busy     = (state_q == ST_GRANT);
   assign own_req  = i_req[owner_q];
   assign own_last = i_last[owner_q];
   assign wr       = busy & own_req & ~i_fifo_full;

   assign o_fifo_wr      = wr;
   assign o_ack          = wr ? grant_q : '0;
   assign o_fifo_wr_data = busy ? own_data : '0;
   assign o_grant        = grant_q;
   assign o_abort        = abort_q;
   assign o_busy         = busy;

   // Next-state: arbitration, packet completion, timeout release
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      abort_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_GRANT;
               owner_d = pick_idx;
               grant_d = pick_sel;
               count_d = '0;
            end
         end
         ST_GRANT: begin
            if (wr) begin
               count_d = '0;
               if (own_last) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  ptr_d   = PW'(wrap_inc(int'(owner_q), N));
               end
            end else if (!own_req) begin
               // Owner idle; a full-FIFO stall with a byte pending neither counts nor clears
               if (count_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  ptr_d   = PW'(wrap_inc(int'(owner_q), N));
                  count_d = '0;
                  abort_d = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         count_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         abort_q <= abort_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
// Self-checking bench for uart_tx_fifo_arbiter (N=4, B=8, TIMEOUT=5).
// A behavioural model tracks owner / pointer / idle count in plain integers
// and predicts every output each cycle; directed scenarios add fixed checks.
module tb_uart_tx_fifo_arbiter;

   localparam int N  = 4;
   localparam int B  = 8;
   localparam int TO = 5;

   logic           i_clk = 1'b0;
   logic           i_reset;
   logic [N-1:0]   i_req;
   logic [N*B-1:0] i_data;
   logic [N-1:0]   i_last;
   logic [N-1:0]   o_ack;
   logic [N-1:0]   o_grant;
   logic           i_fifo_full;
   logic           o_fifo_wr;
   logic [B-1:0]   o_fifo_wr_data;
   logic           o_abort;
   logic           o_busy;

   uart_tx_fifo_arbiter #(.N(N), .B(B), .TIMEOUT(TO)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_req          (i_req),
      .i_data         (i_data),
      .i_last         (i_last),
      .o_ack          (o_ack),
      .o_grant        (o_grant),
      .i_fifo_full    (i_fifo_full),
      .o_fifo_wr      (o_fifo_wr),
      .o_fifo_wr_data (o_fifo_wr_data),
      .o_abort        (o_abort),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model state
   int   m_owner = -1;   // -1 when idle
   int   m_ptr   = 0;
   int   m_idle  = 0;
   bit   m_abort = 1'b0;
   logic [N-1:0] m_ack;

   // Last sampled observations for directed checks
   logic [N-1:0] obs_grant;
   logic         obs_wr;
   logic         obs_abort;
   logic [B-1:0] obs_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_idle  = 0;
      m_abort = 1'b0;
   endtask

   // One clock cycle: apply inputs, check mid-cycle against the model, advance the model
   task automatic cyc(input logic [N-1:0] req, input logic [N*B-1:0] data,
                      input logic [N-1:0] last, input logic full);
      logic [N-1:0] e_grant;
      logic         e_wr;
      logic [B-1:0] e_data;
      bit           nxt_abort;
      i_req = req; i_data = data; i_last = last; i_fifo_full = full;
      e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      e_wr    = (m_owner >= 0) && req[m_owner] && !full;
      e_data  = (m_owner >= 0) ? data[m_owner*B +: B] : '0;
      m_ack   = e_wr ? e_grant : '0;
      @(negedge i_clk);
      obs_grant = o_grant; obs_wr = o_fifo_wr; obs_abort = o_abort; obs_data = o_fifo_wr_data;
      chk("grant", 32'(o_grant), 32'(e_grant));
      chk("ack",   32'(o_ack),   32'(m_ack));
      chk("wr",    32'(o_fifo_wr), 32'(e_wr));
      chk("wdata", 32'(o_fifo_wr_data), 32'(e_data));
      chk("abort", 32'(o_abort), 32'(m_abort));
      chk("busy",  32'(o_busy),  32'(m_owner >= 0));
      @(posedge i_clk);
      nxt_abort = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % N]) begin
               m_owner = (m_ptr + k) % N;
               m_idle  = 0;
            end
         end
      end else if (e_wr) begin
         m_idle = 0;
         if (last[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
         end
      end else if (!req[m_owner]) begin
         m_idle++;
         if (m_idle == TO) begin
            nxt_abort = 1'b1;
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            m_idle = 0;
         end
      end
      m_abort = nxt_abort;
      #1;
   endtask

   function automatic logic [N*B-1:0] lane(input int i, input logic [B-1:0] v);
      logic [N*B-1:0] r;
      r = '0;
      r[i*B +: B] = v;
      return r;
   endfunction

   int           tot;
   int           rem [N];
   int           drop [N];
   logic [B-1:0] pdat [N];
   logic [N-1:0] rq, ls;
   logic [N*B-1:0] dt;
   logic [N-1:0] exp_order [5];

   initial begin
      exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
      i_reset = 1'b1; i_req = '1; i_data = '1; i_last = '1; i_fifo_full = 1'b0;

      // Reset state: outputs quiet even with all requests asserted
      #12;
      chk("rst_grant", 32'(o_grant), 32'h0);
      chk("rst_wr",    32'(o_fifo_wr), 32'h0);
      chk("rst_ack",   32'(o_ack), 32'h0);
      chk("rst_wdata", 32'(o_fifo_wr_data), 32'h0);
      chk("rst_busy",  32'(o_busy), 32'h0);
      chk("rst_abort", 32'(o_abort), 32'h0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      model_reset();

      // All four requesting single-byte packets: grants rotate 0,1,2,3,0
      tot = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 4'b1111, 1'b0);
         tot += int'(obs_wr);
         if (c % 2 == 1) chk("rr_order", 32'(obs_grant), 32'(exp_order[c/2]));
      end
      chk("rr_writes", tot, 5);

      // Three-byte packet on lane 0
      cyc(4'b0001, lane(0, 8'h41), 4'b0000, 1'b0);
      cyc(4'b0001, lane(0, 8'h41), 4'b0000, 1'b0);
      chk("p3_b0", 32'(obs_data), 32'h41);
      cyc(4'b0001, lane(0, 8'h42), 4'b0000, 1'b0);
      cyc(4'b0001, lane(0, 8'h43), 4'b0001, 1'b0);
      chk("p3_b2", 32'(obs_data), 32'h43);
      // Pointer now 1: full contention goes to lane 1
      cyc(4'b1111, {8'h23, 8'h22, 8'h21, 8'h20}, 4'b1111, 1'b0);
      cyc(4'b1111, {8'h23, 8'h22, 8'h21, 8'h20}, 4'b1111, 1'b0);
      chk("p3_ptr", 32'(obs_grant), 32'h2);
      cyc(4'b0000, '0, '0, 1'b0);

      // Owner 2 stalled by a full FIFO for 10 cycles: no write, no abort
      cyc(4'b0100, lane(2, 8'hA1), 4'b0000, 1'b0);
      cyc(4'b0100, lane(2, 8'hA1), 4'b0000, 1'b0);
      tot = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(4'b0100, lane(2, 8'hA2), 4'b0100, 1'b1);
         tot += int'(obs_wr) + int'(obs_abort);
      end
      chk("full_quiet", tot, 0);
      cyc(4'b0100, lane(2, 8'hA2), 4'b0100, 1'b0);
      chk("full_resume", 32'(obs_wr), 32'h1);
      cyc(4'b0000, '0, '0, 1'b0);

      // Owner 1 goes silent after one byte: abort after TIMEOUT idle cycles
      cyc(4'b0010, lane(1, 8'hB1), 4'b0000, 1'b0);
      cyc(4'b0010, lane(1, 8'hB1), 4'b0000, 1'b0);
      for (int d = 0; d < TO; d++) begin
         cyc(4'b0000, '0, '0, 1'b0);
         chk("to_noabort", 32'(obs_abort), 32'h0);
      end
      cyc(4'b0011, lane(0, 8'hB0) | lane(1, 8'hB2), 4'b0011, 1'b0);
      chk("to_abort", 32'(obs_abort), 32'h1);
      chk("to_idle", 32'(obs_grant), 32'h0);
      cyc(4'b0011, lane(0, 8'hB0) | lane(1, 8'hB2), 4'b0011, 1'b0);
      chk("to_regrant", 32'(obs_grant), 32'h1);
      cyc(4'b0000, '0, '0, 1'b0);

      // Reset between edges in the middle of a packet
      cyc(4'b0100, lane(2, 8'hC1), 4'b0000, 1'b0);
      cyc(4'b0100, lane(2, 8'hC1), 4'b0000, 1'b0);
      i_data = lane(2, 8'hC2);
      #3 i_reset = 1'b1;
      #1;
      chk("mrst_grant", 32'(o_grant), 32'h0);
      chk("mrst_wr",    32'(o_fifo_wr), 32'h0);
      chk("mrst_busy",  32'(o_busy), 32'h0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      model_reset();

      // Lane 3 last byte held off by a full FIFO for 3 cycles
      cyc(4'b1000, lane(3, 8'h0D), 4'b1000, 1'b0);
      tot = 0;
      for (int c = 0; c < 3; c++) begin
         cyc(4'b1000, lane(3, 8'h0D), 4'b1000, 1'b1);
         chk("last_hold", 32'(obs_grant), 32'h8);
         tot += int'(obs_wr);
      end
      cyc(4'b1000, lane(3, 8'h0D), 4'b1000, 1'b0);
      tot += int'(obs_wr);
      chk("last_data", 32'(obs_data), 32'h0D);
      chk("last_once", tot, 1);
      cyc(4'b1111, {8'h33, 8'h32, 8'h31, 8'h30}, 4'b1111, 1'b0);
      cyc(4'b1111, {8'h33, 8'h32, 8'h31, 8'h30}, 4'b1111, 1'b0);
      chk("wrap_ptr", 32'(obs_grant), 32'h1);
      cyc(4'b0000, '0, '0, 1'b0);

      // Randomised producers: variable packet lengths, FIFO full, request gaps
      for (int i = 0; i < N; i++) begin rem[i] = 0; drop[i] = 0; pdat[i] = '0; end
      for (int c = 0; c < 1500; c++) begin
         rq = '0; ls = '0; dt = '0;
         for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(2, 0) == 0) begin
               rem[i]  = int'($urandom_range(4, 1));
               pdat[i] = B'($urandom);
            end
            if (rem[i] > 0 && drop[i] == 0 && $urandom_range(29, 0) == 0)
               drop[i] = int'($urandom_range(8, 1));
            if (drop[i] > 0) drop[i]--;
            else if (rem[i] > 0) rq[i] = 1'b1;
            ls[i] = (rem[i] == 1);
            dt[i*B +: B] = pdat[i];
         end
         cyc(rq, dt, ls, ($urandom_range(3, 0) == 0));
         for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
               rem[i]--;
               pdat[i] = B'($urandom);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
